iir_cascade_wb: RTL and testbench

IIR_CASCADE_WB -- requirements
Module: iir_cascade_wb

---
 rtl/iir_cascade_pkg.sv | 42 ++++
 rtl/iir_mac_sat.sv | 75 +++++++
 rtl/iir_cascade_wb.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_iir_cascade_wb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_cascade_pkg.sv
// Shared definitions for the Wishbone biquad cascade.
// Holds register byte offsets, CTRL/STATUS bit positions, the sequencer
// state type and the accumulator sizing helper used by the top level and
// the MAC/saturation datapath.
package iir_cascade_pkg;

  // Taps per biquad: b0, b1, b2, a1, a2.
  localparam int TAPS = 5;

  // Guard bits on top of the full product width so five products never wrap.
  localparam int ACC_GUARD_BITS = 3;

  // Register byte offsets. Coefficients occupy 0x14*s + 4*k below these.
  localparam int REG_CTRL   = 'hC0;
  localparam int REG_STATUS = 'hC4;
  localparam int REG_X      = 'hC8;
  localparam int REG_Y      = 'hCC;

  // CTRL bit positions.
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS bit positions.
  localparam int ST_BUSY    = 0;
  localparam int ST_Y_VALID = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_DROP    = 3;
  localparam int ST_CFG_ERR = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_WB,
    S_DONE
  } state_e;

  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + ACC_GUARD_BITS;
  endfunction

endpackage

// File: rtl/iir_mac_sat.sv
// Shared multiply-accumulate and output conditioning for all biquad sections.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   mac_en       accumulate one product this cycle
//   acc_load     start a new sum (discard previous accumulator contents)
//   subtract     subtract the product instead of adding it (feedback taps)
//   sample, coef signed operands
//   result       accumulator >>> FRAC_BITS, saturated to DATA_WIDTH
//   ovf          high while result is being clipped
module iir_mac_sat
  import iir_cascade_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int COEF_WIDTH = 16,
  parameter int FRAC_BITS  = 14,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + ACC_GUARD_BITS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mac_en,
  input  logic                         acc_load,
  input  logic                         subtract,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [COEF_WIDTH-1:0] coef,
  output logic signed [DATA_WIDTH-1:0] result,
  output logic                         ovf
);

  localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
  localparam int SHR_W  = ACC_WIDTH - FRAC_BITS;

  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_WIDTH-1:0] prod_ext;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic        [SHR_W-1:0]     shifted;
  logic        [SHR_W-DATA_WIDTH:0] head;
  logic                        in_range;

  always_comb begin
    prod     = sample * coef;
    prod_ext = {{(ACC_WIDTH - PROD_W){prod[PROD_W-1]}}, prod};
    acc_base = acc_load ? '0 : acc_q;
    acc_d    = acc_q;
    if (mac_en) begin
      acc_d = subtract ? (acc_base - prod_ext) : (acc_base + prod_ext);
    end
  end

  // Dropping the low FRAC_BITS of a two's-complement value is a floor
  // (toward -inf). The value fits DATA_WIDTH only when every bit from the
  // output sign bit upward is a copy of the sign.
  always_comb begin
    shifted  = acc_q[ACC_WIDTH-1:FRAC_BITS];
    head     = shifted[SHR_W-1:DATA_WIDTH-1];
    in_range = (&head) | ~(|head);
    ovf      = ~in_range;
    if (in_range) begin
      result = shifted[DATA_WIDTH-1:0];
    end else if (shifted[SHR_W-1]) begin
      result = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      result = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/iir_cascade_wb.sv
// Cascade of direct-form-I biquads behind a Wishbone classic slave port.
// One shared MAC walks 5 taps per section, then a write-back cycle saturates
// the section result and shifts that section's delay line.
// Ports:
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   wb_adr_i/dat_i/we/stb/cyc   Wishbone request (byte address, [1:0] ignored)
//   wb_dat_o, wb_ack_o          registered read data and one-cycle ack
//   irq_o                       CTRL.irq_en AND STATUS.y_valid
module iir_cascade_wb
  import iir_cascade_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 8,
  parameter int NUM_SECTIONS = 2,
  parameter int COEF_WIDTH   = 16,
  parameter int FRAC_BITS    = 14
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  input  logic                  wb_we_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_cyc_i,
  output logic                  wb_ack_o,
  output logic                  irq_o
);

  localparam int ACC_W  = acc_width(DATA_WIDTH, COEF_WIDTH);
  localparam int NCOEF  = TAPS * NUM_SECTIONS;
  localparam int CIDX_W = $clog2(NCOEF);
  localparam int SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam int AW     = ADDR_WIDTH - 2;
  localparam logic signed [COEF_WIDTH-1:0] B0_ONE = COEF_WIDTH'(1 << FRAC_BITS);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;

  state_e                        state_d, state_q;
  logic [2:0]                    tap_d, tap_q;
  logic [SEC_W-1:0]              sec_d, sec_q;
  sample_t                       cur_x_d, cur_x_q;
  sample_t                       pend_d, pend_q;
  logic                          pend_full_d, pend_full_q;
  sample_t                       y_d, y_q;
  logic signed [COEF_WIDTH-1:0]  coef_d [NCOEF];
  logic signed [COEF_WIDTH-1:0]  coef_q [NCOEF];
  sample_t                       x1_d [NUM_SECTIONS];
  sample_t                       x1_q [NUM_SECTIONS];
  sample_t                       x2_d [NUM_SECTIONS];
  sample_t                       x2_q [NUM_SECTIONS];
  sample_t                       y1_d [NUM_SECTIONS];
  sample_t                       y1_q [NUM_SECTIONS];
  sample_t                       y2_d [NUM_SECTIONS];
  sample_t                       y2_q [NUM_SECTIONS];
  logic                          enable_d, enable_q, irq_en_d, irq_en_q;
  logic                          y_valid_d, y_valid_q, ovf_d, ovf_q;
  logic                          drop_d, drop_q, cfg_err_d, cfg_err_q;
  logic                          ack_d, ack_q;
  logic [DATA_WIDTH-1:0]         dat_d, dat_q;

  logic                          access, wr, rd, busy, do_clear;
  logic [AW-1:0]                 adr_word;
  logic                          coef_hit, is_ctrl, is_status, is_x, is_y;
  logic [CIDX_W-1:0]             bus_cidx, mac_cidx;
  logic [4:0]                    status_bits;
  sample_t                       mac_sample, mac_result;
  logic                          mac_en, mac_load, mac_sub, mac_ovf;
  logic                          unused_adr;

  assign unused_adr = ^wb_adr_i[1:0];
  assign busy       = (state_q != S_IDLE);
  assign wb_ack_o   = ack_q;
  assign wb_dat_o   = dat_q;
  assign irq_o      = irq_en_q & y_valid_q;

  // An access is taken only while ack is low, so a held strobe is not
  // acknowledged twice in consecutive cycles.
  always_comb begin
    access    = wb_stb_i & wb_cyc_i & ~ack_q;
    wr        = access & wb_we_i;
    rd        = access & ~wb_we_i;
    adr_word  = wb_adr_i[ADDR_WIDTH-1:2];
    coef_hit  = 32'(adr_word) < NCOEF;
    bus_cidx  = CIDX_W'(adr_word);
    is_ctrl   = (adr_word == AW'(REG_CTRL >> 2));
    is_status = (adr_word == AW'(REG_STATUS >> 2));
    is_x      = (adr_word == AW'(REG_X >> 2));
    is_y      = (adr_word == AW'(REG_Y >> 2));
    status_bits             = '0;
    status_bits[ST_BUSY]    = busy;
    status_bits[ST_Y_VALID] = y_valid_q;
    status_bits[ST_OVF]     = ovf_q;
    status_bits[ST_DROP]    = drop_q;
    status_bits[ST_CFG_ERR] = cfg_err_q;
  end

  // Coefficient memory is laid out so the word address equals s*5+k.
  always_comb begin
    mac_cidx = CIDX_W'(32'(sec_q) * TAPS + 32'(tap_q));
    mac_en   = (state_q == S_MAC);
    mac_load = (tap_q == 3'd0);
    mac_sub  = (tap_q >= 3'd3);
    case (tap_q)
      3'd0:    mac_sample = cur_x_q;
      3'd1:    mac_sample = x1_q[sec_q];
      3'd2:    mac_sample = x2_q[sec_q];
      3'd3:    mac_sample = y1_q[sec_q];
      default: mac_sample = y2_q[sec_q];
    endcase
  end

  iir_mac_sat #(
    .DATA_WIDTH(DATA_WIDTH),
    .COEF_WIDTH(COEF_WIDTH),
    .FRAC_BITS (FRAC_BITS),
    .ACC_WIDTH (ACC_W)
  ) u_mac (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .mac_en  (mac_en),
    .acc_load(mac_load),
    .subtract(mac_sub),
    .sample  (mac_sample),
    .coef    (coef_q[mac_cidx]),
    .result  (mac_result),
    .ovf     (mac_ovf)
  );

  // Bus side effects come first so that FSM events landing on the same edge
  // (y_valid set in DONE, ovf set in WB) win over a clear from the bus.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    sec_d       = sec_q;
    cur_x_d     = cur_x_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    y_d         = y_q;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    enable_d    = enable_q;
    irq_en_d    = irq_en_q;
    y_valid_d   = y_valid_q;
    ovf_d       = ovf_q;
    drop_d      = drop_q;
    cfg_err_d   = cfg_err_q;
    ack_d       = access;
    dat_d       = '0;
    do_clear    = 1'b0;

    if (rd) begin
      if (coef_hit) begin
        dat_d = {{(DATA_WIDTH-COEF_WIDTH){coef_q[bus_cidx][COEF_WIDTH-1]}}, coef_q[bus_cidx]};
      end else if (is_ctrl) begin
        dat_d = DATA_WIDTH'({irq_en_q, 1'b0, enable_q});
      end else if (is_status) begin
        dat_d = DATA_WIDTH'(status_bits);
      end else if (is_y) begin
        dat_d     = y_q;
        y_valid_d = 1'b0;
      end
    end

    if (wr) begin
      if (coef_hit) begin
        if (busy) cfg_err_d = 1'b1;
        else      coef_d[bus_cidx] = wb_dat_i[COEF_WIDTH-1:0];
      end else if (is_ctrl) begin
        enable_d = wb_dat_i[CTRL_ENABLE];
        irq_en_d = wb_dat_i[CTRL_IRQ_EN];
        do_clear = wb_dat_i[CTRL_CLEAR];
      end else if (is_status) begin
        if (wb_dat_i[ST_OVF])     ovf_d     = 1'b0;
        if (wb_dat_i[ST_DROP])    drop_d    = 1'b0;
        if (wb_dat_i[ST_CFG_ERR]) cfg_err_d = 1'b0;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (pend_full_q) begin
          cur_x_d     = pend_q;
          pend_full_d = 1'b0;
          sec_d       = '0;
          tap_d       = '0;
          state_d     = S_MAC;
        end
      end
      S_MAC: begin
        if (tap_q == 3'd4) state_d = S_WB;
        else               tap_d   = tap_q + 3'd1;
      end
      S_WB: begin
        x2_d[sec_q] = x1_q[sec_q];
        x1_d[sec_q] = cur_x_q;
        y2_d[sec_q] = y1_q[sec_q];
        y1_d[sec_q] = mac_result;
        cur_x_d     = mac_result;
        if (mac_ovf) ovf_d = 1'b1;
        tap_d = '0;
        if (sec_q == SEC_W'(NUM_SECTIONS - 1)) begin
          state_d = S_DONE;
        end else begin
          sec_d   = sec_q + SEC_W'(1);
          state_d = S_MAC;
        end
      end
      default: begin
        y_d       = cur_x_q;
        y_valid_d = 1'b1;
        sec_d     = '0;
        tap_d     = '0;
        if (pend_full_q) begin
          cur_x_d     = pend_q;
          pend_full_d = 1'b0;
          state_d     = S_MAC;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase

    // Evaluated after the FSM so a slot freed on this edge can take the sample.
    if (wr && is_x && enable_q) begin
      if (pend_full_d) begin
        drop_d = 1'b1;
      end else begin
        pend_d      = wb_dat_i;
        pend_full_d = 1'b1;
      end
    end

    if (do_clear) begin
      state_d     = S_IDLE;
      tap_d       = '0;
      sec_d       = '0;
      pend_full_d = 1'b0;
      x1_d        = '{default: '0};
      x2_d        = '{default: '0};
      y1_d        = '{default: '0};
      y2_d        = '{default: '0};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      tap_q       <= '0;
      sec_q       <= '0;
      cur_x_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      y_q         <= '0;
      for (int i = 0; i < NCOEF; i++) begin
        coef_q[i] <= ((i % TAPS) == 0) ? B0_ONE : '0;
      end
      x1_q        <= '{default: '0};
      x2_q        <= '{default: '0};
      y1_q        <= '{default: '0};
      y2_q        <= '{default: '0};
      enable_q    <= 1'b1;
      irq_en_q    <= 1'b0;
      y_valid_q   <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      sec_q       <= sec_d;
      cur_x_q     <= cur_x_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      y_q         <= y_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
      enable_q    <= enable_d;
      irq_en_q    <= irq_en_d;
      y_valid_q   <= y_valid_d;
      ovf_q       <= ovf_d;
      drop_q      <= drop_d;
      cfg_err_q   <= cfg_err_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
    end
  end

endmodule

// File: tb/tb_iir_cascade_wb.sv
// Directed bench for iir_cascade_wb (NUM_SECTIONS=2, FRAC_BITS=14).
// Register-level behaviour is driven from a table of bus records; filter
// behaviour, latency, pending/drop, clear and reset use short sequences.
module tb_iir_cascade_wb;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic [7:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        irq_o;

  int compares;
  int errors;

  localparam logic [7:0] A_CTRL   = 8'hC0;
  localparam logic [7:0] A_STATUS = 8'hC4;
  localparam logic [7:0] A_X      = 8'hC8;
  localparam logic [7:0] A_Y      = 8'hCC;

  typedef struct packed {
    logic        we;
    logic [7:0]  adr;
    logic [31:0] wdat;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [20];

  iir_cascade_wb dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_we_i (wb_we_i),
    .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o),
    .irq_o   (irq_o)
  );

  initial begin
    wb_clk_i = 1'b0;
    forever #5 wb_clk_i = ~wb_clk_i;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compares++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge wb_clk_i);
      #1;
    end
  endtask

  task automatic doReset();
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    wb_adr_i = '0;
    wb_dat_i = '0;
    wb_rst_i = 1'b1;
    waitCycles(2);
    wb_rst_i = 1'b0;
  endtask

  task automatic wbAccess(input logic we, input logic [7:0] adr, input logic [31:0] wdat,
                          output logic [31:0] rdat);
    int waited;
    wb_adr_i = adr;
    wb_dat_i = wdat;
    wb_we_i  = we;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    waited   = 0;
    do begin
      @(posedge wb_clk_i);
      #1;
      waited++;
    end while (wb_ack_o !== 1'b1 && waited < 8);
    if (wb_ack_o !== 1'b1) begin
      compares++;
      errors++;
      $display("[TB] FAIL ack_timeout adr 0x%02h: ack=%b after %0d cycles, required 1", adr, wb_ack_o, waited);
    end
    rdat     = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wbWrite(input logic [7:0] adr, input logic [31:0] wdat);
    logic [31:0] dummy;
    wbAccess(1'b1, adr, wdat, dummy);
  endtask

  task automatic wbCheckRead(input string name, input logic [7:0] adr, input logic [31:0] expected);
    logic [31:0] rdat;
    wbAccess(1'b0, adr, 32'h0, rdat);
    checkOutput(name, rdat, expected);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] rdat;
    wbAccess(v.we, v.adr, v.wdat, rdat);
    if (!v.we) checkOutput($sformatf("table[%0d] rd 0x%02h", idx, v.adr), rdat, v.exp);
  endtask

  task automatic waitYValid(input string name);
    logic [31:0] st;
    int polls;
    st    = '0;
    polls = 0;
    do begin
      wbAccess(1'b0, A_STATUS, 32'h0, st);
      polls++;
    end while (st[1] !== 1'b1 && polls < 40);
    compares++;
    if (st[1] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s y_valid: status 0x%08h after %0d polls, required bit1=1", name, st, polls);
    end
  endtask

  task automatic runSample(input string name, input logic [31:0] x, input logic [31:0] y_exp);
    wbWrite(A_X, x);
    waitYValid(name);
    wbCheckRead(name, A_Y, y_exp);
  endtask

  initial begin
    int cnt;
    compares = 0;
    errors   = 0;

    vecs[0]  = '{1'b0, 8'hC0, 32'h0,        32'h0000_0001};
    vecs[1]  = '{1'b0, 8'hC4, 32'h0,        32'h0000_0000};
    vecs[2]  = '{1'b0, 8'hCC, 32'h0,        32'h0000_0000};
    vecs[3]  = '{1'b0, 8'h00, 32'h0,        32'h0000_4000};
    vecs[4]  = '{1'b0, 8'h14, 32'h0,        32'h0000_4000};
    vecs[5]  = '{1'b0, 8'h04, 32'h0,        32'h0000_0000};
    vecs[6]  = '{1'b0, 8'h24, 32'h0,        32'h0000_0000};
    vecs[7]  = '{1'b1, 8'h0C, 32'h0000_E000, 32'h0};
    vecs[8]  = '{1'b0, 8'h0C, 32'h0,        32'hFFFF_E000};
    vecs[9]  = '{1'b1, 8'h10, 32'hFFFF_1234, 32'h0};
    vecs[10] = '{1'b0, 8'h10, 32'h0,        32'h0000_1234};
    vecs[11] = '{1'b1, 8'h28, 32'hDEAD_BEEF, 32'h0};
    vecs[12] = '{1'b0, 8'h28, 32'h0,        32'h0000_0000};
    vecs[13] = '{1'b1, 8'hD0, 32'h1234_5678, 32'h0};
    vecs[14] = '{1'b0, 8'hD0, 32'h0,        32'h0000_0000};
    vecs[15] = '{1'b1, 8'hC0, 32'h0000_0007, 32'h0};
    vecs[16] = '{1'b0, 8'hC0, 32'h0,        32'h0000_0005};
    vecs[17] = '{1'b1, 8'hC0, 32'h0000_0001, 32'h0};
    vecs[18] = '{1'b0, 8'h0D, 32'h0,        32'hFFFF_E000};
    vecs[19] = '{1'b0, 8'h14, 32'h0,        32'h0000_4000};

    // Reset values on the ports.
    doReset();
    checkOutput("reset ack", 32'(wb_ack_o), 32'h0);
    checkOutput("reset dat", wb_dat_o, 32'h0);
    checkOutput("reset irq", 32'(irq_o), 32'h0);

    // Ack is a single-cycle pulse even when the strobe is held.
    wb_adr_i = A_CTRL;
    wb_we_i  = 1'b0;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    waitCycles(1);
    checkOutput("ack first cycle", 32'(wb_ack_o), 32'h1);
    checkOutput("ack read data", wb_dat_o, 32'h1);
    waitCycles(1);
    checkOutput("ack second cycle", 32'(wb_ack_o), 32'h0);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    waitCycles(1);

    // Register map table.
    for (int i = 0; i < 20; i++) applyStimulus(vecs[i], i);

    // Identity cascade, y_valid, irq gated off.
    doReset();
    wbWrite(A_X, 32'd1000);
    waitYValid("identity");
    checkOutput("identity irq", 32'(irq_o), 32'h0);
    wbCheckRead("identity Y", A_Y, 32'd1000);
    wbCheckRead("identity status", A_STATUS, 32'h0);

    // Exact latency measured on irq_o.
    doReset();
    wbWrite(A_CTRL, 32'h5);
    wbWrite(A_X, 32'd1000);
    cnt = 0;
    do begin
      waitCycles(1);
      cnt++;
    end while (irq_o !== 1'b1 && cnt < 40);
    checkOutput("latency edges", 32'(cnt), 32'd14);
    wbCheckRead("latency Y", A_Y, 32'd1000);
    checkOutput("irq after Y read", 32'(irq_o), 32'h0);

    // Half-gain b0.
    doReset();
    wbWrite(8'h00, 32'd8192);
    runSample("b0 half x4000", 32'd4000, 32'd2000);
    runSample("b0 half x0", 32'd0, 32'd0);

    // One-pole feedback y = x + 0.5*y1.
    doReset();
    wbWrite(8'h0C, 32'h0000_E000);
    runSample("pole x1000", 32'd1000, 32'd1000);
    runSample("pole x0 a", 32'd0, 32'd500);
    runSample("pole x0 b", 32'd0, 32'd250);

    // Saturation and sticky ovf.
    doReset();
    wbWrite(8'h00, 32'd32767);
    runSample("sat Y", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wbCheckRead("sat status", A_STATUS, 32'h0000_0004);
    wbWrite(A_STATUS, 32'h4);
    wbCheckRead("ovf cleared", A_STATUS, 32'h0);

    // Pending, drop and coefficient write while busy.
    doReset();
    wbWrite(A_X, 32'd5);
    wbWrite(A_X, 32'd6);
    wbWrite(A_X, 32'd7);
    wbWrite(8'h00, 32'd1234);
    wbCheckRead("busy status", A_STATUS, 32'h0000_0019);
    waitYValid("pending first");
    wbCheckRead("pending Y first", A_Y, 32'd5);
    waitYValid("pending second");
    wbCheckRead("pending Y second", A_Y, 32'd6);
    wbCheckRead("coef kept", 8'h00, 32'h0000_4000);
    wbCheckRead("drop status", A_STATUS, 32'h0000_0018);

    // Clear mid-computation.
    doReset();
    wbWrite(8'h0C, 32'h0000_E000);
    wbWrite(A_X, 32'd1000);
    waitYValid("pre-clear");
    wbWrite(A_X, 32'd5000);
    waitCycles(1);
    wbWrite(A_CTRL, 32'h3);
    wbCheckRead("clear status", A_STATUS, 32'h0000_0002);
    wbCheckRead("clear Y kept", A_Y, 32'd1000);
    runSample("after clear", 32'd1000, 32'd1000);

    // Enable off discards samples silently.
    doReset();
    wbWrite(A_CTRL, 32'h0);
    wbWrite(A_X, 32'd1000);
    waitCycles(20);
    wbCheckRead("disabled status", A_STATUS, 32'h0);
    wbCheckRead("disabled Y", A_Y, 32'h0);

    // Reset in the middle of a computation.
    doReset();
    wbWrite(A_X, 32'd1000);
    waitCycles(4);
    doReset();
    wbCheckRead("midreset status", A_STATUS, 32'h0);
    wbCheckRead("midreset Y", A_Y, 32'h0);
    waitCycles(20);
    wbCheckRead("midreset later status", A_STATUS, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
